// File: rtl/cwc_trig_capture.sv
// Trigger/capture controller for the on-chip logic analyser: it matches probe conditions and writes samples into a ring buffer.
// Optional macro CWC_CAP_QUAL_EN adds sample qualification, so only qualifying samples are written.
module cwc_trig_capture #(
  parameter int unsigned DIN_W  = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              trig_clk,
  input  logic              trig_rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [DIN_W-1:0]  din,
  input  logic [DIN_W-1:0]  cfg_mask,
  input  logic [DIN_W-1:0]  cfg_value,
  input  logic [DIN_W-1:0]  cfg_edge,
  input  logic              cfg_mode,
  input  logic [CNT_W-1:0]  cfg_trig_cnt,
  input  logic [ADDR_W-1:0] cfg_post,
`ifdef CWC_CAP_QUAL_EN
  input  logic [DIN_W-1:0]  cfg_qual_mask,
  input  logic [DIN_W-1:0]  cfg_qual_value,
`endif
  output logic              wt_ce,
  output logic              wt_en,
  output logic [ADDR_W-1:0] wt_addr,
  output logic [DIN_W-1:0]  wt_data,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              armed,
  output logic              triggered,
  output logic              done,
  output logic              wrapped
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_POST, ST_DONE} state_t;

  state_t            state_q;
  logic [DIN_W-1:0]  din_q, din_d;
  logic              first_q;
  logic [DIN_W-1:0]  mask_r, value_r, edge_r;
  logic              mode_r;
  logic [CNT_W-1:0]  target_r, cnt_q, cnt_inc;
  logic [ADDR_W-1:0] post_r, post_cnt, ptr;
  logic [DIN_W-1:0]  level_ok, edge_ok, bit_ok;
  logic              match, hit, qual_ok, wr;

`ifdef CWC_CAP_QUAL_EN
  logic [DIN_W-1:0]  qmask_r, qvalue_r;
  assign qual_ok = ((din_q ^ qvalue_r) & qmask_r) == '0;
`else
  assign qual_ok = 1'b1;
`endif

  // Per-bit compare of the stage-1 sample; edge bits also need a change from the previous sample.
  always_comb begin
    level_ok = ~(din_q ^ value_r);
    edge_ok  = level_ok & (din_q ^ din_d) & {DIN_W{~first_q}};
    bit_ok   = (edge_r & edge_ok) | (~edge_r & level_ok);
  end

  assign match   = mode_r ? (|(bit_ok & mask_r)) : (&(bit_ok | ~mask_r));
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign hit     = (state_q == ST_WAIT) && match && (cnt_inc == target_r);
  assign wr      = ((state_q == ST_WAIT) && (qual_ok || hit)) ||
                   ((state_q == ST_POST) && (post_cnt != '0) && qual_ok);

  always_ff @(posedge trig_clk or posedge trig_rst) begin
    if (trig_rst) begin
      state_q   <= ST_IDLE;
      din_q     <= '0;
      din_d     <= '0;
      first_q   <= 1'b0;
      mask_r    <= '0;
      value_r   <= '0;
      edge_r    <= '0;
      mode_r    <= 1'b0;
      target_r  <= '0;
      cnt_q     <= '0;
      post_r    <= '0;
      post_cnt  <= '0;
      ptr       <= '0;
`ifdef CWC_CAP_QUAL_EN
      qmask_r   <= '0;
      qvalue_r  <= '0;
`endif
      wt_ce     <= 1'b0;
      wt_en     <= 1'b0;
      wt_addr   <= '0;
      wt_data   <= '0;
      trig_addr <= '0;
      armed     <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      din_q   <= din;
      din_d   <= din_q;
      wt_data <= din_q;
      wt_en   <= 1'b0;
      if (abort) begin
        state_q   <= ST_IDLE;
        wt_ce     <= 1'b0;
        trig_addr <= '0;
        armed     <= 1'b0;
        triggered <= 1'b0;
        done      <= 1'b0;
        wrapped   <= 1'b0;
      end else begin
        if (wr) begin
          wt_en   <= 1'b1;
          wt_addr <= ptr;
          ptr     <= ptr + ADDR_W'(1);
          if (ptr == '1) wrapped <= 1'b1;
        end
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (arm) begin
              mask_r    <= cfg_mask;
              value_r   <= cfg_value;
              edge_r    <= cfg_edge;
              mode_r    <= cfg_mode;
              target_r  <= (cfg_trig_cnt == '0) ? CNT_W'(1) : cfg_trig_cnt;
              post_r    <= cfg_post;
`ifdef CWC_CAP_QUAL_EN
              qmask_r   <= cfg_qual_mask;
              qvalue_r  <= cfg_qual_value;
`endif
              cnt_q     <= '0;
              ptr       <= '0;
              wt_addr   <= '0;
              first_q   <= 1'b1;
              trig_addr <= '0;
              wrapped   <= 1'b0;
              triggered <= 1'b0;
              done      <= 1'b0;
              armed     <= 1'b1;
              wt_ce     <= 1'b1;
              state_q   <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            first_q <= 1'b0;
            if (match) cnt_q <= cnt_inc;
            if (hit) begin
              trig_addr <= ptr;
              triggered <= 1'b1;
              post_cnt  <= post_r;
              state_q   <= ST_POST;
            end
          end
          ST_POST: begin
            if (post_cnt == '0) begin
              state_q <= ST_DONE;
              done    <= 1'b1;
              armed   <= 1'b0;
              wt_ce   <= 1'b0;
            end else if (qual_ok) begin
              post_cnt <= post_cnt - ADDR_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cwc_trig_capture.sv
// Scoreboard bench for cwc_trig_capture: the stimulus pushes the expected RAM writes and trigger addresses, and a monitor checks them.
module tb_cwc_trig_capture;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst, arm, abort, mode;
  logic [DW-1:0] din, mask, value, edg;
  logic [CW-1:0] tcnt;
  logic [AW-1:0] post;
`ifdef CWC_CAP_QUAL_EN
  logic [DW-1:0] qmask, qvalue;
`endif
  logic          wt_ce, wt_en, armed, triggered, done, wrapped;
  logic [AW-1:0] wt_addr, trig_addr;
  logic [DW-1:0] wt_data;

  always #5 clk = ~clk;

  cwc_trig_capture #(.DIN_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .trig_clk(clk), .trig_rst(rst), .arm(arm), .abort(abort), .din(din),
    .cfg_mask(mask), .cfg_value(value), .cfg_edge(edg), .cfg_mode(mode),
    .cfg_trig_cnt(tcnt), .cfg_post(post),
`ifdef CWC_CAP_QUAL_EN
    .cfg_qual_mask(qmask), .cfg_qual_value(qvalue),
`endif
    .wt_ce(wt_ce), .wt_en(wt_en), .wt_addr(wt_addr), .wt_data(wt_data),
    .trig_addr(trig_addr), .armed(armed), .triggered(triggered),
    .done(done), .wrapped(wrapped)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_w[$];
  logic [AW-1:0] exp_t[$];
  logic [DW-1:0] vec[64];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Sample index i (driven at the i-th edge, the arm edge being index 0) is written to address i mod 16.
  task automatic push_lin(input int n);
    for (int i = 0; i < n; i++) exp_w.push_back(wr_t'{a: AW'(i), d: vec[i]});
  endtask

  task automatic run(input string name, input logic [DW-1:0] m, input logic [DW-1:0] v,
                     input logic [DW-1:0] e, input logic md, input logic [CW-1:0] c,
                     input logic [AW-1:0] p, input logic wrap_exp);
    int i;
    @(negedge clk);
    mask = m; value = v; edg = e; mode = md; tcnt = c; post = p;
    arm = 1'b1; din = vec[0];
    i = 1;
    while (i < 300) begin
      @(negedge clk);
      arm = 1'b0;
      if (done) break;
      din = vec[(i < 64) ? i : 63];
      i++;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_triggered"}, 32'(triggered), 32'd1);
    chk({name, "_wrapped"}, 32'(wrapped), 32'(wrap_exp));
    chk({name, "_wt_en_off"}, 32'(wt_en), 32'd0);
    chk({name, "_wt_ce_off"}, 32'(wt_ce), 32'd0);
    chk({name, "_pending_writes"}, 32'(exp_w.size()), 32'd0);
    chk({name, "_pending_trig"}, 32'(exp_t.size()), 32'd0);
  endtask

  // Monitor: every presented write and every trigger rise is compared against the queues.
  initial begin
    logic prev_t;
    wr_t  ew;
    prev_t = 1'b0;
    forever begin
      @(negedge clk);
      if (wt_en === 1'b1) begin
        if (exp_w.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", wt_addr, wt_data);
        end else begin
          ew = exp_w.pop_front();
          chk("wr_addr", 32'(wt_addr), 32'(ew.a));
          chk("wr_data", 32'(wt_data), 32'(ew.d));
        end
      end
      if (triggered === 1'b1 && !prev_t) begin
        if (exp_t.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_trigger: got trig_addr %0h, expected no trigger", trig_addr);
        end else begin
          chk("trig_addr", 32'(trig_addr), 32'(exp_t.pop_front()));
        end
      end
      prev_t = triggered;
    end
  end

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; din = '0;
    mask = '0; value = '0; edg = '0; mode = 1'b0; tcnt = '0; post = '0;
`ifdef CWC_CAP_QUAL_EN
    qmask = '0; qvalue = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_outputs", {wt_ce, wt_en, armed, triggered, done, wrapped, wt_addr, trig_addr, wt_data},
        32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Level AND trigger at sample 20, four post writes, buffer wraps.
    for (int i = 0; i < 64; i++) vec[i] = DW'(i);
    vec[20] = 8'hA5;
    push_lin(25); exp_t.push_back(AW'(4));
    run("level_and", 8'hFF, 8'hA5, 8'h00, 1'b0, CW'(1), AW'(4), 1'b1);

    // Second rising edge of bit 0 triggers; the first one only counts.
    for (int i = 0; i < 64; i++) vec[i] = 8'h01;
    vec[2] = 8'h00; vec[5] = 8'h00;
    push_lin(8); exp_t.push_back(AW'(6));
    run("edge_cnt2", 8'h01, 8'h01, 8'h01, 1'b0, CW'(2), AW'(1), 1'b0);

    // Trigger at sample 40 with post=0: the trigger sample is the last write.
    for (int i = 0; i < 64; i++) vec[i] = DW'(i);
    vec[40] = 8'hEE;
    push_lin(41); exp_t.push_back(AW'(8));
    run("wrap_post0", 8'hFF, 8'hEE, 8'h00, 1'b0, CW'(1), AW'(0), 1'b1);

    // Empty mask in AND mode matches the first sample; a count of 0 acts as 1.
    for (int i = 0; i < 64; i++) vec[i] = DW'(8'h5A + i);
    push_lin(1); exp_t.push_back(AW'(0));
    run("empty_and", 8'h00, 8'h00, 8'h00, 1'b0, CW'(0), AW'(0), 1'b0);

    // OR mode: only bit 7 matching at sample 5 fires the trigger.
    for (int i = 0; i < 64; i++) vec[i] = 8'h70;
    vec[5] = 8'hF0;
    push_lin(8); exp_t.push_back(AW'(5));
    run("or_mode", 8'hF0, 8'h80, 8'h00, 1'b1, CW'(1), AW'(2), 1'b0);

    // Abort during POST, after the trigger at sample 2.
    for (int i = 0; i < 64; i++) vec[i] = DW'(8'h11 * (i + 1));
    push_lin(5); exp_t.push_back(AW'(2));
    @(negedge clk);
    mask = 8'hFF; value = 8'h33; edg = 8'h00; mode = 1'b0; tcnt = CW'(1); post = AW'(8);
    arm = 1'b1; din = vec[0];
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      arm = 1'b0; din = vec[i];
    end
    @(negedge clk);
    abort = 1'b1; din = vec[6];
    @(negedge clk);
    abort = 1'b0;
    chk("abort_wt_en", 32'(wt_en), 32'd0);
    chk("abort_status", {wt_ce, armed, triggered, done, wrapped, trig_addr}, 32'd0);
    chk("abort_pending_writes", 32'(exp_w.size()), 32'd0);

    // Abort and arm in the same cycle: abort wins and the block stays idle.
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_arm_idle", {wt_ce, wt_en, armed, triggered, done}, 32'd0);

`ifdef CWC_CAP_QUAL_EN
    // Qualifier on bit 0: only odd samples are written, at contiguous addresses.
    qmask = 8'h01; qvalue = 8'h01;
    for (int i = 0; i < 64; i++) vec[i] = DW'(i);
    for (int j = 0; j < 7; j++) exp_w.push_back(wr_t'{a: AW'(j), d: DW'(2 * j + 1)});
    exp_t.push_back(AW'(4));
    run("qual_odd", 8'hFF, 8'h09, 8'h00, 1'b0, CW'(1), AW'(2), 1'b0);
    qmask = '0; qvalue = '0;
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
